// File: rtl/memoria_pkg.sv
// Shared types and default parameter values for the handshaked RAM block.
package memoria_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACCESS = 2'd3
  } state_t;

  localparam int DATA_W_DEF     = 8;
  localparam int ADDR_W_DEF     = 8;
  localparam int WAIT_CYC_DEF   = 0;
  localparam int INIT_CLEAR_DEF = 1;

  // Width of the wait-state down-counter (WAIT_CYC is at most 15).
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/memoria_ram_hs_if.sv
// Request/acknowledge bus of the handshaked RAM.
interface memoria_ram_hs_if
  import memoria_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              clr;
  logic              ready;
  logic              ack;
  logic [DATA_W-1:0] data_out;

  modport master (
    output req, we, address, data_in, clr,
    input  ready, ack, data_out
  );

  modport slave (
    input  req, we, address, data_in, clr,
    output ready, ack, data_out
  );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM with write enable and registered read port.
// The storage array has no reset; only the read register is cleared.
module mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array write port.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Registered read; holds its value when no read is performed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memoria_ram_hs.sv
// Handshaked RAM controller: zero-fill sequence, request capture,
// programmable wait states and a one-cycle completion pulse.
module memoria_ram_hs
  import memoria_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int WAIT_CYC   = WAIT_CYC_DEF,
  parameter int INIT_CLEAR = INIT_CLEAR_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  memoria_ram_hs_if.slave  bus
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LD = WAIT_CNT_W'(WAIT_CYC);
  localparam state_t RST_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;

  state_t                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]       ptr_q, ptr_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    we_q, we_d;
  logic                    ack_q;

  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;

  // Next-state, counter and capture logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (&ptr_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // clr wins over req when both arrive together.
        if (bus.clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.address;
          data_d  = bus.data_in;
          cnt_d   = WAIT_LD;
          state_d = (WAIT_CYC > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - WAIT_CNT_W'(1);
        if (cnt_q == WAIT_CNT_W'(1)) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers: state, counters and the completion pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ack_q   <= (state_q == ST_ACCESS);
    end
  end

  // Capture registers for the access in flight.
  always_ff @(posedge clk) begin
    we_q   <= we_d;
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // Memory port: zero-fill in CLEAR, captured access in ACCESS. Gating with
  // rst_n makes a reset on the access edge abort the write.
  assign mem_en    = rst_n && ((state_q == ST_CLEAR) || (state_q == ST_ACCESS));
  assign mem_we    = (state_q == ST_CLEAR) || we_q;
  assign mem_addr  = (state_q == ST_CLEAR) ? ptr_q : addr_q;
  assign mem_wdata = (state_q == ST_CLEAR) ? '0 : data_q;

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  assign bus.ready    = (state_q == ST_IDLE);
  assign bus.ack      = ack_q;
  assign bus.data_out = mem_rdata;

endmodule

// File: tb/tb_memoria_ram_hs.sv
// Scoreboard bench for memoria_ram_hs: two instances (no wait states with
// zero-fill, three wait states without zero-fill) share one clock.
module tb_memoria_ram_hs;

  localparam int WAIT_A = 0;
  localparam int WAIT_B = 3;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t       q_a[$];
  exp_t       q_b[$];
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] dout_a;
  logic [7:0] dout_b;

  memoria_ram_hs_if #(.DATA_W(8), .ADDR_W(8)) ifa ();
  memoria_ram_hs_if #(.DATA_W(8), .ADDR_W(8)) ifb ();

  memoria_ram_hs #(.DATA_W(8), .ADDR_W(8), .WAIT_CYC(WAIT_A), .INIT_CLEAR(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_a_n),
    .bus   (ifa)
  );

  memoria_ram_hs #(.DATA_W(8), .ADDR_W(8), .WAIT_CYC(WAIT_B), .INIT_CLEAR(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .bus   (ifb)
  );

  always #5 clk = ~clk;

  // Edge counter: at a falling edge, cyc is the index of the last rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for instance A: every ack must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ifa.ack === 1'b1) begin
      if (q_a.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL a_extra_ack: ack at cycle %0d, required no ack", cyc);
      end else begin
        e = q_a.pop_front();
        check("a_ack_cycle", cyc, e.cyc);
        check("a_data_out", ifa.data_out, e.data);
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    exp_t e;
    if (ifb.ack === 1'b1) begin
      if (q_b.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL b_extra_ack: ack at cycle %0d, required no ack", cyc);
      end else begin
        e = q_b.pop_front();
        check("b_ack_cycle", cyc, e.cyc);
        check("b_data_out", ifb.data_out, e.data);
      end
    end
  end

  task automatic wait_ready(input int sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ((sel == 0) ? ifa.ready : ifb.ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_ready_%0d: ready stayed 0, required 1", sel);
    end
  endtask

  // Issue one access when ready; push its expected ack unless it is to be aborted.
  task automatic issue(input int sel, input bit wr, input logic [7:0] addr,
                       input logic [7:0] din, input bit exp_ack, input bit hold);
    bit   ok;
    exp_t e;
    wait_ready(sel, ok);
    if (!ok) return;
    if (sel == 0) begin
      ifa.req = 1'b1; ifa.we = wr; ifa.address = addr; ifa.data_in = din; ifa.clr = 1'b0;
    end else begin
      ifb.req = 1'b1; ifb.we = wr; ifb.address = addr; ifb.data_in = din; ifb.clr = 1'b0;
    end
    if (exp_ack) begin
      e.cyc = cyc + 2 + ((sel == 0) ? WAIT_A : WAIT_B);
      if (sel == 0) begin
        if (wr) mem_a[addr] = din;
        else    dout_a = mem_a[addr];
        e.data = dout_a;
        q_a.push_back(e);
      end else begin
        if (wr) mem_b[addr] = din;
        else    dout_b = mem_b[addr];
        e.data = dout_b;
        q_b.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    // Scramble the inputs after capture; the access in flight must not see it.
    if (sel == 0) begin
      ifa.address = ~addr; ifa.data_in = ~din; ifa.we = ~wr;
      if (!hold) ifa.req = 1'b0;
    end else begin
      ifb.address = ~addr; ifb.data_in = ~din; ifb.we = ~wr;
      if (!hold) ifb.req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cnt;
    ifa.req = 1'b0; ifa.we = 1'b0; ifa.address = '0; ifa.data_in = '0; ifa.clr = 1'b0;
    ifb.req = 1'b0; ifb.we = 1'b0; ifb.address = '0; ifb.data_in = '0; ifb.clr = 1'b0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    dout_a = 8'h00;
    dout_b = 8'h00;

    // Reset values of both instances.
    repeat (3) @(negedge clk);
    check("a_rst_ready", ifa.ready, 0);
    check("a_rst_ack", ifa.ack, 0);
    check("a_rst_dout", ifa.data_out, 0);
    check("b_rst_ready", ifb.ready, 1);
    check("b_rst_ack", ifb.ack, 0);
    check("b_rst_dout", ifb.data_out, 0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    // Zero-fill after reset keeps ready low for 256 cycles.
    cnt = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ifa.ready) break;
      cnt++;
    end
    check("a_clear_cycles", cnt, 256);

    // Array is zero after the fill.
    issue(0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    issue(0, 1'b0, 8'h7F, 8'h00, 1'b1, 1'b0);
    issue(0, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0);

    // Simple write then read, no wait states.
    issue(0, 1'b1, 8'h10, 8'hA5, 1'b1, 1'b0);
    issue(0, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0);

    // Back-to-back write and read with req held high.
    issue(0, 1'b1, 8'h20, 8'h3C, 1'b1, 1'b1);
    issue(0, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0);

    // clr and req together: zero-fill runs, the request is dropped.
    wait_ready(0, ok);
    ifa.clr = 1'b1; ifa.req = 1'b1; ifa.we = 1'b1; ifa.address = 8'h30; ifa.data_in = 8'h77;
    @(posedge clk);
    #1;
    ifa.clr = 1'b0;
    ifa.req = 1'b0;
    for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ifa.ready) break;
      cnt++;
    end
    check("a_clr_cycles", cnt, 256);
    issue(0, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0);
    issue(0, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0);
    issue(0, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0);

    // Instance B: three wait states, prior value at 0x05.
    issue(1, 1'b1, 8'h05, 8'h11, 1'b1, 1'b0);
    issue(1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0);
    // req/clr pulses while busy are ignored.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("b_busy_ready", ifb.ready, 0);
      ifb.req = 1'b1; ifb.we = 1'b1; ifb.address = 8'h05; ifb.data_in = 8'hEE;
      ifb.clr = (k == 1);
    end
    @(negedge clk);
    ifb.req = 1'b0;
    ifb.clr = 1'b0;
    issue(1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0);

    // Reset during the WAIT of a write aborts it.
    issue(1, 1'b1, 8'h05, 8'h55, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_b_n = 1'b0;
    @(negedge clk);
    check("b_abort_ready", ifb.ready, 1);
    check("b_abort_ack", ifb.ack, 0);
    check("b_abort_dout", ifb.data_out, 0);
    rst_b_n = 1'b1;
    dout_b = 8'h00;
    repeat (6) @(negedge clk);
    issue(1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0);

    repeat (10) @(negedge clk);
    check("a_missing_ack", q_a.size(), 0);
    check("b_missing_ack", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memoria_ram_hs.md
MEMORIA_RAM_HS -- requirements
Module: memoria_ram_hs

Interface
REQ-001 Parameter DATA_W, default 8: memory word width in bits.
REQ-002 Parameter ADDR_W, default 8: address width; DEPTH = 2**ADDR_W words, full decode, no out-of-range addresses.
REQ-003 Parameter WAIT_CYC, default 0: wait states inserted per access; legal range 0..15.
REQ-004 Parameter INIT_CLEAR, default 1: when 1, the array is zero-filled after reset.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 req  input  1  access request; sampled only while ready=1.
REQ-008 we  input  1  1 = write, 0 = read; captured with req.
REQ-009 address  input  ADDR_W  access address; captured with req.
REQ-010 data_in  input  DATA_W  write data; captured with req.
REQ-011 clr  input  1  request to re-run the zero-fill sequence; sampled only while ready=1.
REQ-012 ready  output  1  high when the block is in IDLE and able to accept req or clr.
REQ-013 ack  output  1  one-cycle completion pulse for each accepted req.
REQ-014 data_out  output  DATA_W  read data, valid while ack=1 for a read.

Function
REQ-015 The block SHALL implement states CLEAR, IDLE, WAIT and ACCESS.
REQ-016 ready SHALL be decoded from the registered state (state==IDLE) only, with no combinational path from any input.
REQ-017 CLEAR: write 0 to mem[ptr] each cycle, ptr counting 0..DEPTH-1; after the write to DEPTH-1, go to IDLE. Duration is exactly DEPTH cycles.
REQ-018 IDLE with clr=1: go to CLEAR with ptr=0. clr has priority over req when both are high.
REQ-019 IDLE with req=1 (and clr=0): capture we, address and data_in at that edge N. Go to WAIT if WAIT_CYC>0, else go to ACCESS.
REQ-020 WAIT SHALL last exactly WAIT_CYC cycles, counted by a down-counter loaded at capture, then go to ACCESS.
REQ-021 ACCESS, write: mem[addr_q] <= data_q; data_out is unchanged.
REQ-022 ACCESS, read: data_out <= mem[addr_q].
REQ-023 ACCESS, either direction: ack <= 1, next state IDLE.
REQ-024 Latency: ack SHALL be high in the cycle after edge N+1+WAIT_CYC, for exactly one cycle.
REQ-025 ack and ready MAY be high together; a req seen in that cycle is accepted, giving back-to-back throughput of one access per WAIT_CYC+2 cycles.
REQ-026 req or clr while ready=0 SHALL be ignored: no queueing and no ack.
REQ-027 Input changes after capture SHALL have no effect on the access in flight.
REQ-028 A read of an address written by the immediately preceding access SHALL return the new data.
REQ-029 data_out SHALL hold its last value outside read-ack cycles.

Reset
REQ-030 rst_n=0 sampled at posedge SHALL force: ack=0, data_out=0, counters=0, ptr=0.
REQ-031 Post-reset state SHALL be CLEAR if INIT_CLEAR=1, else IDLE.
REQ-032 Reset mid-operation (WAIT or ACCESS edge coincident with reset) SHALL abort the access with no write and no ack.
REQ-033 With INIT_CLEAR=0, memory contents SHALL survive reset; the array itself has no reset.

Structure
REQ-034 Package memoria_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-035 The storage SHALL be a sub-module mem_array: single-port, synchronous, with write-enable and registered read, parametrised by DATA_W and ADDR_W.
REQ-036 The controller FSM, counters and capture registers SHALL live in memoria_ram_hs.

Verification
REQ-037 Reset with INIT_CLEAR=1, ADDR_W=8 -> ready=0 for 256 cycles, then 1; reading 0x00, 0x7F and 0xFF returns 0x00.
REQ-038 WAIT_CYC=0: write 0xA5 to 0x10 at edge N -> ack high after edge N+1; read 0x10 -> data_out=0xA5 with ack.
REQ-039 WAIT_CYC=3: read accepted at edge N -> ack high only after edge N+4; req pulses during the busy cycles produce no extra ack.
REQ-040 Back-to-back write 0x3C to 0x20 then read 0x20, with req held high -> two acks 2 cycles apart; read returns 0x3C.
REQ-041 rst_n low during WAIT of a write of 0x55 to 0x05, INIT_CLEAR=0 -> no ack; mem[0x05] keeps its prior value.
REQ-042 clr and req together in IDLE -> CLEAR entered, req dropped; afterwards mem[any]=0x00.
